knn_distance_scheduler: RTL and testbench



---
 rtl/knn_sched_if.sv | 59 +++++
 rtl/knn_distance_scheduler.sv | 170 +++++++++++++++++
 tb/tb_knn_distance_scheduler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_sched_if.sv
// Bundle of the scheduler's handshake and data buses: run control, memory
// read port, distance_calculator chunk port and sorter result port.
// master = scheduler side, slave = surrounding system.
interface knn_sched_if #(
    parameter int W            = 32,
    parameter int MAX_ELEMENTS = 16,
    parameter int TYPE_W       = 2,
    parameter int IDX_W        = 3,
    parameter int CHUNK_W      = 2
);
    // run control
    logic                      start;
    logic                      busy;
    logic                      all_done;
    // memory read port
    logic                      rd_en;
    logic [IDX_W-1:0]          rd_sample;
    logic [CHUNK_W-1:0]        rd_chunk;
    logic [W*MAX_ELEMENTS-1:0] mem_training_data;
    logic [TYPE_W-1:0]         mem_training_type;
    logic [W*MAX_ELEMENTS-1:0] mem_input_data;
    // distance_calculator port
    logic                      dc_ready;
    logic [W*MAX_ELEMENTS-1:0] dc_training_data;
    logic [TYPE_W-1:0]         dc_training_data_type;
    logic [W*MAX_ELEMENTS-1:0] dc_input_data;
    logic                      dc_data_request;
    logic                      dc_done;
    logic [2*W-1:0]            dc_distance;
    logic [TYPE_W-1:0]         dc_data_type;
    // sorter result port
    logic                      res_valid;
    logic                      res_ready;
    logic [2*W-1:0]            res_distance;
    logic [TYPE_W-1:0]         res_type;
    logic [IDX_W-1:0]          res_index;
    // running nearest neighbour
    logic [2*W-1:0]            best_distance;
    logic [TYPE_W-1:0]         best_type;
    logic [IDX_W-1:0]          best_index;

    modport master (
        input  start, mem_training_data, mem_training_type, mem_input_data,
               dc_data_request, dc_done, dc_distance, dc_data_type, res_ready,
        output busy, all_done, rd_en, rd_sample, rd_chunk,
               dc_ready, dc_training_data, dc_training_data_type, dc_input_data,
               res_valid, res_distance, res_type, res_index,
               best_distance, best_type, best_index
    );

    modport slave (
        output start, mem_training_data, mem_training_type, mem_input_data,
               dc_data_request, dc_done, dc_distance, dc_data_type, res_ready,
        input  busy, all_done, rd_en, rd_sample, rd_chunk,
               dc_ready, dc_training_data, dc_training_data_type, dc_input_data,
               res_valid, res_distance, res_type, res_index,
               best_distance, best_type, best_index
    );
endinterface

// File: rtl/knn_distance_scheduler.sv
// KNN distance scheduler: walks NUM_TRAIN training samples, streams each one
// to distance_calculator in MAX_ELEMENTS-wide chunks and forwards every
// (distance, type, index) result to the sorter over valid/ready.
// Optional macro KNN_NEAREST_TRACK_EN: keep the nearest result of the run in
// best_*; when undefined best_* read as 0 and no comparator exists.
module knn_distance_scheduler #(
    parameter int M            = 6,
    parameter int N            = 10,
    parameter int W            = 32,
    parameter int MAX_ELEMENTS = 16,
    parameter int TYPE_W       = 2,
    parameter int NUM_TRAIN    = 8,
    parameter int IDX_W        = 3
) (
    input  logic       clk,
    input  logic       rst,
    knn_sched_if.master bus
);
    localparam int CHUNKS  = (M*N + MAX_ELEMENTS - 1) / MAX_ELEMENTS;
    localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK  = CHUNK_W'(CHUNKS - 1);
    localparam logic [IDX_W-1:0]   LAST_SAMPLE = IDX_W'(NUM_TRAIN - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, SEND, WAIT_REQ, WAIT_DONE, OUTPUT
    } state_t;

    state_t                             state_q;
    logic [IDX_W-1:0]                   sample_q;
    logic [CHUNK_W-1:0]                 chunk_q;
    logic                               busy_q, all_done_q, rd_en_q, dc_ready_q;
    logic [MAX_ELEMENTS-1:0][W-1:0]     dc_trn_q, dc_inp_q;
    logic [TYPE_W-1:0]                  dc_type_q;
    logic                               res_valid_q;
    logic [2*W-1:0]                     res_dist_q;
    logic [TYPE_W-1:0]                  res_type_q;
    logic [IDX_W-1:0]                   res_idx_q;

    logic [MAX_ELEMENTS-1:0][W-1:0]     mem_trn, mem_inp, trn_d, inp_d;
    logic [MAX_ELEMENTS-1:0]            lane_keep;

    assign mem_trn = bus.mem_training_data;
    assign mem_inp = bus.mem_input_data;

    // Lanes past the end of the M*N vector are zeroed in both operands so
    // they add nothing to the distance.
    for (genvar l = 0; l < MAX_ELEMENTS; l++) begin : g_lane
        assign lane_keep[l] = (int'(chunk_q) * MAX_ELEMENTS + l) < M*N;
        assign trn_d[l]     = lane_keep[l] ? mem_trn[l] : '0;
        assign inp_d[l]     = lane_keep[l] ? mem_inp[l] : '0;
    end

    // Main sequencer: all handshake outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sample_q    <= '0;
            chunk_q     <= '0;
            busy_q      <= 1'b0;
            all_done_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            dc_ready_q  <= 1'b0;
            dc_trn_q    <= '0;
            dc_inp_q    <= '0;
            dc_type_q   <= '0;
            res_valid_q <= 1'b0;
            res_dist_q  <= '0;
            res_type_q  <= '0;
            res_idx_q   <= '0;
        end else begin
            rd_en_q    <= 1'b0;
            dc_ready_q <= 1'b0;
            all_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sample_q <= '0;
                        chunk_q  <= '0;
                        busy_q   <= 1'b1;
                        rd_en_q  <= 1'b1;
                        state_q  <= FETCH;
                    end
                end
                FETCH: state_q <= LOAD;
                LOAD: begin
                    dc_trn_q   <= trn_d;
                    dc_inp_q   <= inp_d;
                    dc_type_q  <= bus.mem_training_type;
                    dc_ready_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: state_q <= (chunk_q == LAST_CHUNK) ? WAIT_DONE : WAIT_REQ;
                WAIT_REQ: begin
                    if (bus.dc_data_request) begin
                        chunk_q <= chunk_q + 1'b1;
                        rd_en_q <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                WAIT_DONE: begin
                    if (bus.dc_done) begin
                        res_dist_q  <= bus.dc_distance;
                        res_type_q  <= bus.dc_data_type;
                        res_idx_q   <= sample_q;
                        res_valid_q <= 1'b1;
                        state_q     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (sample_q == LAST_SAMPLE) begin
                            all_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            sample_q <= sample_q + 1'b1;
                            chunk_q  <= '0;
                            rd_en_q  <= 1'b1;
                            state_q  <= FETCH;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy                  = busy_q;
    assign bus.all_done              = all_done_q;
    assign bus.rd_en                 = rd_en_q;
    assign bus.rd_sample             = sample_q;
    assign bus.rd_chunk              = chunk_q;
    assign bus.dc_ready              = dc_ready_q;
    assign bus.dc_training_data      = dc_trn_q;
    assign bus.dc_input_data         = dc_inp_q;
    assign bus.dc_training_data_type = dc_type_q;
    assign bus.res_valid             = res_valid_q;
    assign bus.res_distance          = res_dist_q;
    assign bus.res_type              = res_type_q;
    assign bus.res_index             = res_idx_q;

`ifdef KNN_NEAREST_TRACK_EN
    logic [2*W-1:0]    best_dist_q;
    logic [TYPE_W-1:0] best_type_q;
    logic [IDX_W-1:0]  best_idx_q;

    // Nearest-so-far: first sample always wins, later ones only if strictly closer.
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && bus.start)) begin
            best_dist_q <= '0;
            best_type_q <= '0;
            best_idx_q  <= '0;
        end else if (state_q == OUTPUT && bus.res_ready &&
                     (sample_q == '0 || res_dist_q < best_dist_q)) begin
            best_dist_q <= res_dist_q;
            best_type_q <= res_type_q;
            best_idx_q  <= res_idx_q;
        end
    end

    assign bus.best_distance = best_dist_q;
    assign bus.best_type     = best_type_q;
    assign bus.best_index    = best_idx_q;
`else
    assign bus.best_distance = '0;
    assign bus.best_type     = '0;
    assign bus.best_index    = '0;
`endif
endmodule

// File: tb/tb_knn_distance_scheduler.sv
// Directed bench for knn_distance_scheduler: default 6x10 build (4 chunks)
// plus a 2x4 build (single chunk), each with a memory and calculator model.
module tb_knn_distance_scheduler;
    localparam int LW = 32;
    localparam int LN = 16;
    localparam logic [63:0] TBL [8] = '{64'd50, 64'd20, 64'd20, 64'd70,
                                        64'd90, 64'd30, 64'd40, 64'd60};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    knn_sched_if #(.CHUNK_W(2)) bus_a ();
    knn_sched_if #(.CHUNK_W(1)) bus_b ();

    knn_distance_scheduler u_a (.clk(clk), .rst(rst), .bus(bus_a));
    knn_distance_scheduler #(.M(2), .N(4)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_checks = 0;
    int n_fail   = 0;
    bit tbl_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ssd(input logic [LW*LN-1:0] a, input logic [LW*LN-1:0] b);
        logic [63:0] s, d;
        logic [31:0] x, y;
        s = '0;
        for (int l = 0; l < LN; l++) begin
            x = a[l*LW +: LW];
            y = b[l*LW +: LW];
            d = (x > y) ? 64'(x - y) : 64'(y - x);
            s += d * d;
        end
        return s;
    endfunction

    // Memory: all training lanes 1, query 0, label = sample%4; junk when idle.
    always @(posedge clk) begin
        if (bus_a.rd_en === 1'b1) begin
            bus_a.mem_training_data <= {LN{32'd1}};
            bus_a.mem_input_data    <= '0;
            bus_a.mem_training_type <= 2'(bus_a.rd_sample % 4);
        end else begin
            bus_a.mem_training_data <= {LN{32'd7}};
            bus_a.mem_input_data    <= {LN{32'd2}};
            bus_a.mem_training_type <= 2'd3;
        end
        if (bus_b.rd_en === 1'b1) begin
            bus_b.mem_training_data <= {LN{32'd1}};
            bus_b.mem_input_data    <= '0;
            bus_b.mem_training_type <= 2'(bus_b.rd_sample % 4);
        end else begin
            bus_b.mem_training_data <= {LN{32'd7}};
            bus_b.mem_input_data    <= {LN{32'd2}};
            bus_b.mem_training_type <= 2'd3;
        end
    end

    // Calculator model A: 4 chunks per sample, request/done after a short delay.
    int          a_req_t, a_done_t, a_seen, a_rdy, a_last_rdy, a_idx;
    logic [63:0] a_acc;
    logic        a_hi_zero;
    always @(posedge clk) begin
        if (rst) begin
            a_req_t <= 0; a_done_t <= 0; a_seen <= 0; a_rdy <= 0;
            a_last_rdy <= 0; a_idx <= 0; a_acc <= '0; a_hi_zero <= 1'b0;
            bus_a.dc_data_request <= 1'b0; bus_a.dc_done <= 1'b0;
            bus_a.dc_distance <= '0; bus_a.dc_data_type <= '0;
        end else begin
            bus_a.dc_data_request <= 1'b0;
            bus_a.dc_done         <= 1'b0;
            if (a_req_t == 1) bus_a.dc_data_request <= 1'b1;
            if (a_req_t > 0) a_req_t <= a_req_t - 1;
            if (a_done_t == 1) begin
                bus_a.dc_done      <= 1'b1;
                bus_a.dc_distance  <= tbl_mode ? TBL[a_idx] : a_acc;
                bus_a.dc_data_type <= bus_a.dc_training_data_type;
                a_last_rdy <= a_rdy;
                a_rdy      <= 0;
                a_acc      <= '0;
                a_idx      <= (a_idx + 1) % 8;
            end
            if (a_done_t > 0) a_done_t <= a_done_t - 1;
            if (bus_a.dc_ready === 1'b1) begin
                a_acc <= a_acc + ssd(bus_a.dc_training_data, bus_a.dc_input_data);
                a_rdy <= a_rdy + 1;
                if (a_seen == 3) begin
                    a_hi_zero <= (bus_a.dc_training_data[LN*LW-1:12*LW] == '0) &&
                                 (bus_a.dc_input_data[LN*LW-1:12*LW] == '0);
                    a_seen   <= 0;
                    a_done_t <= 3;
                end else begin
                    a_seen  <= a_seen + 1;
                    a_req_t <= 3;
                end
            end
        end
    end

    // Calculator model B: one chunk per sample, never requests more.
    int          b_done_t, b_rdy, b_last_rdy;
    logic [63:0] b_dist;
    logic        b_hi_zero;
    always @(posedge clk) begin
        if (rst) begin
            b_done_t <= 0; b_rdy <= 0; b_last_rdy <= 0; b_dist <= '0; b_hi_zero <= 1'b0;
            bus_b.dc_data_request <= 1'b0; bus_b.dc_done <= 1'b0;
            bus_b.dc_distance <= '0; bus_b.dc_data_type <= '0;
        end else begin
            bus_b.dc_done <= 1'b0;
            if (b_done_t == 1) begin
                bus_b.dc_done      <= 1'b1;
                bus_b.dc_distance  <= b_dist;
                bus_b.dc_data_type <= bus_b.dc_training_data_type;
                b_last_rdy <= b_rdy;
                b_rdy      <= 0;
            end
            if (b_done_t > 0) b_done_t <= b_done_t - 1;
            if (bus_b.dc_ready === 1'b1) begin
                b_dist    <= ssd(bus_b.dc_training_data, bus_b.dc_input_data);
                b_hi_zero <= (bus_b.dc_training_data[LN*LW-1:8*LW] == '0) &&
                             (bus_b.dc_input_data[LN*LW-1:8*LW] == '0);
                b_rdy     <= b_rdy + 1;
                b_done_t  <= 2;
            end
        end
    end

    initial begin
        int t, k;
        bus_a.start = 1'b0; bus_a.res_ready = 1'b0;
        bus_b.start = 1'b0; bus_b.res_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy",     bus_a.busy, 0);
        chk("rst_all_done", bus_a.all_done, 0);
        chk("rst_rd_en",    bus_a.rd_en, 0);
        chk("rst_dc_ready", bus_a.dc_ready, 0);
        chk("rst_res_vld",  bus_a.res_valid, 0);
        chk("rst_dc_trn",   64'(bus_a.dc_training_data[63:0]), 0);
        chk("rst_res_dist", bus_a.res_distance, 0);
        chk("rst_best",     bus_a.best_distance, 0);
        chk("rst_b_busy",   bus_b.busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // run 1: full sweep, back-pressure on sample 2, start while busy
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        chk("r1_busy",   bus_a.busy, 1);
        chk("r1_rd_en",  bus_a.rd_en, 1);
        chk("r1_rd_smp", bus_a.rd_sample, 0);
        chk("r1_rd_chk", bus_a.rd_chunk, 0);
        for (int i = 0; i < 8; i++) begin
            t = 0;
            while (bus_a.res_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
            chk("r1_valid",  bus_a.res_valid, 1);
            chk("r1_dist",   bus_a.res_distance, 60);
            chk("r1_type",   bus_a.res_type, 64'(i % 4));
            chk("r1_index",  bus_a.res_index, 64'(i));
            chk("r1_n_rdy",  64'(a_last_rdy), 4);
            chk("r1_hi0",    a_hi_zero, 1);
            if (i == 2) begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("bp_valid", bus_a.res_valid, 1);
                    chk("bp_dist",  bus_a.res_distance, 60);
                    chk("bp_index", bus_a.res_index, 2);
                    chk("bp_rd_en", bus_a.rd_en, 0);
                end
            end
            bus_a.res_ready = 1'b1;
            @(negedge clk);
            bus_a.res_ready = 1'b0;
            chk("r1_vld_fall", bus_a.res_valid, 0);
            if (i == 0) begin
                bus_a.start = 1'b1;
                @(negedge clk);
                bus_a.start = 1'b0;
                chk("busy_start_busy", bus_a.busy, 1);
            end
            if (i == 7) begin
                chk("r1_all_done", bus_a.all_done, 1);
                chk("r1_idle",     bus_a.busy, 0);
`ifdef KNN_NEAREST_TRACK_EN
                chk("r1_best_d", bus_a.best_distance, 60);
                chk("r1_best_i", bus_a.best_index, 0);
`else
                chk("r1_best_d", bus_a.best_distance, 0);
                chk("r1_best_i", bus_a.best_index, 0);
`endif
                @(negedge clk);
                chk("r1_done_pulse", bus_a.all_done, 0);
            end
        end

        // run 2: reset in WAIT_REQ of sample 3 chunk 1
        bus_a.res_ready = 1'b1;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        k = 0; t = 0;
        while (k < 3 && t < 1000) begin
            @(negedge clk); t++;
            if (bus_a.res_valid === 1'b1) k++;
        end
        chk("r2_three_res", 64'(k), 3);
        t = 0;
        while (!(bus_a.rd_en === 1'b1 && bus_a.rd_sample == 3 && bus_a.rd_chunk == 1) && t < 100) begin
            @(negedge clk); t++;
        end
        chk("r2_fetch_s3c1", bus_a.rd_en, 1);
        t = 0;
        while (bus_a.dc_ready !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        chk("r2_send", bus_a.dc_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("r2_rst_busy",  bus_a.busy, 0);
        chk("r2_rst_rdy",   bus_a.dc_ready, 0);
        chk("r2_rst_vld",   bus_a.res_valid, 0);
        chk("r2_rst_rd_en", bus_a.rd_en, 0);
        chk("r2_rst_dc",    64'(bus_a.dc_training_data[63:0]), 0);

        // run 3: restart after reset, table distances for nearest tracking
        tbl_mode = 1'b1;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        chk("r3_rd_en",  bus_a.rd_en, 1);
        chk("r3_rd_smp", bus_a.rd_sample, 0);
        chk("r3_rd_chk", bus_a.rd_chunk, 0);
        k = 0; t = 0;
        while (bus_a.all_done !== 1'b1 && t < 2000) begin
            @(negedge clk); t++;
            if (bus_a.res_valid === 1'b1 && k < 8) begin
                chk("r3_dist",  bus_a.res_distance, TBL[k]);
                chk("r3_index", bus_a.res_index, 64'(k));
                k++;
            end
        end
        chk("r3_n_res",    64'(k), 8);
        chk("r3_all_done", bus_a.all_done, 1);
`ifdef KNN_NEAREST_TRACK_EN
        chk("r3_best_d", bus_a.best_distance, 20);
        chk("r3_best_i", bus_a.best_index, 1);
        chk("r3_best_t", bus_a.best_type, 1);
`else
        chk("r3_best_d", bus_a.best_distance, 0);
        chk("r3_best_i", bus_a.best_index, 0);
        chk("r3_best_t", bus_a.best_type, 0);
`endif
        bus_a.res_ready = 1'b0;

        // run B: 2x4 build, single chunk per sample
        bus_b.res_ready = 1'b1;
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        k = 0; t = 0;
        while (bus_b.all_done !== 1'b1 && t < 1000) begin
            @(negedge clk); t++;
            if (bus_b.res_valid === 1'b1 && k < 8) begin
                chk("b_dist",  bus_b.res_distance, 8);
                chk("b_index", bus_b.res_index, 64'(k));
                chk("b_type",  bus_b.res_type, 64'(k % 4));
                chk("b_n_rdy", 64'(b_last_rdy), 1);
                chk("b_hi0",   b_hi_zero, 1);
                k++;
            end
        end
        chk("b_n_res",    64'(k), 8);
        chk("b_all_done", bus_b.all_done, 1);
        bus_b.res_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
